pc_unit: RTL and testbench
==========================

# pc_unit

Parametrised program-counter unit for the Phantom-R fetch stage, and the successor to the basic sequential PC. It holds the fetch address and advances it under a valid/ready fetch handshake. It accepts prioritised trap and branch/jump redirects, and predicts return targets from a small circular return-address stack (RAS). A misaligned redirect target halts fetch until a trap redirect arrives.

## Interface
Parameters:
- XLEN, 32, address width in bits
- RESET_VECTOR, 32'h0000_0000, Iaddress value after reset; must be 4-byte aligned
- RAS_DEPTH, 4, RAS entries; power of two, 2..16

Ports:
- clk  input  1  clock; all state updates on rising edge
- n_reset  input  1  reset, synchronous, active-low
- if_ready  input  1  instruction memory accepts Iaddress this cycle
- stall  input  1  hold the PC (pipeline back-pressure)
- trap_en  input  1  take trap; highest priority
- trap_vector  input  XLEN  trap target
- redirect_en  input  1  resolved branch/jump from execute
- redirect_target  input  XLEN  branch/jump target
- ras_push  input  1  decoded call; push ras_push_addr
- ras_push_addr  input  XLEN  return address (call PC + 4)
- ras_pop  input  1  decoded return; predict next PC from RAS top
- Iaddress  output  XLEN  current fetch address
- pc_valid  output  1  Iaddress is a valid fetch request
- misaligned_fault  output  1  registered; a misaligned target was rejected
- fault_addr  output  XLEN  the offending target, held while the fault is set
- ras_empty  output  1  RAS count == 0 (combinational from count)

## Operation
- States:
  - BOOT: entered on reset; pc_valid=0; unconditionally moves to RUN next cycle.
  - RUN: pc_valid=1.
  - HALT: pc_valid=0; entered on a misaligned redirect target.
- "Fire" means pc_valid && if_ready && !stall.
- Next-PC priority in RUN:
  1. trap_en → trap_vector
  2. redirect_en → redirect_target
  3. ras_pop && fire && !ras_empty → RAS top
  4. fire → Iaddress + 4
  5. otherwise hold
- trap_en and redirect_en flush: they load regardless of stall or if_ready.
- Alignment check: trap_vector and redirect_target are checked only when selected. If target[1:0] != 0:
  - Iaddress holds its current value.
  - misaligned_fault is set and fault_addr captures the target.
  - State moves to HALT.
- A RAS-sourced target with low bits set is loaded as-is; low bits are not checked.
- HALT: only trap_en exits. It loads trap_vector (alignment-checked), clears misaligned_fault and returns to RUN. redirect_en, ras_push and ras_pop are ignored in HALT.
- RAS: circular buffer with top pointer and count (0..RAS_DEPTH). Updates happen only in RUN, on fire.
  - Push: write at top+1 and increment count. When full, count saturates and the oldest entry is overwritten.
  - Pop: decrement count. On an empty pop, next PC falls through to sequential and count stays 0.
  - Push and pop together: top entry is replaced with ras_push_addr; count unchanged. Next PC is the old top.
  - trap_en clears count to 0.
  - redirect_en in the same cycle as push or pop: RAS is not updated.
- Arithmetic: Iaddress + 4 wraps modulo 2^XLEN with no flag.

## Timing
- Reset (n_reset=0 at a clock edge):
  - Iaddress=RESET_VECTOR, pc_valid=0, misaligned_fault=0, fault_addr=0.
  - RAS count=0, so ras_empty=1. State=BOOT.
- Reset has priority over every input and aborts any state, including HALT.
- First pc_valid=1 appears 1 cycle after reset is released, with Iaddress=RESET_VECTOR.
- All outputs are registered except ras_empty. Every selected next PC appears on Iaddress 1 cycle after the sampling edge.
- A redirect or trap asserted in cycle N gives Iaddress=target in cycle N+1, even while stalled.
- misaligned_fault rises 1 cycle after the offending request. pc_valid drops in the same cycle.
- Fetch handshake: while pc_valid=1 and the request has not fired, Iaddress must stay stable except for trap or redirect.

## Test plan
- Reset and boot: RESET_VECTOR=32'h100, release reset, hold if_ready=1 → cycle 1: Iaddress=0x100, pc_valid=1; then 0x104, 0x108.
- Stall and handshake: if_ready=0 for 3 cycles at 0x200 → Iaddress holds 0x200. stall=1 with redirect_en to 0x400 → 0x400 next cycle.
- Priority: trap_en (0x80) and redirect_en (0x300) in the same cycle → 0x80, and RAS count becomes 0.
- RAS with RAS_DEPTH=4:
  - Push 0x10, 0x20, 0x30, 0x40, 0x50, then pop 5 times → targets 0x50, 0x40, 0x30, 0x20, then sequential; ras_empty=1 after the 4th pop.
  - Simultaneous push 0x60 and pop with top 0x50 → next PC 0x50, top entry becomes 0x60.
- Misaligned: redirect_target=0x1002 → misaligned_fault=1, fault_addr=0x1002, pc_valid=0, Iaddress unchanged. redirect_en in HALT is ignored. trap_en to 0x80 → RUN at 0x80 with the fault cleared.
- Wrap and reset mid-operation: Iaddress=32'hFFFF_FFFC with fire → 0x0. Assert n_reset=0 while in HALT → all outputs at reset values on the next edge.

Source files
------------

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with valid/ready handshake,
// prioritised trap/redirect, circular return-address stack and
// misaligned-target halt.
module pc_unit #(
   parameter int unsigned XLEN         = 32,
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned RAS_DEPTH    = 4
) (
   input  logic            clk,
   input  logic            n_reset,
   input  logic            if_ready,
   input  logic            stall,
   input  logic            trap_en,
   input  logic [XLEN-1:0] trap_vector,
   input  logic            redirect_en,
   input  logic [XLEN-1:0] redirect_target,
   input  logic            ras_push,
   input  logic [XLEN-1:0] ras_push_addr,
   input  logic            ras_pop,
   output logic [XLEN-1:0] Iaddress,
   output logic            pc_valid,
   output logic            misaligned_fault,
   output logic [XLEN-1:0] fault_addr,
   output logic            ras_empty
);

   localparam int unsigned PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            fault_q, fault_d;
   logic [XLEN-1:0] fault_addr_q, fault_addr_d;
   logic [PW-1:0]   top_q, top_d;
   logic [CW-1:0]   count_q, count_d;
   logic [XLEN-1:0] ras_q [RAS_DEPTH];

   logic            ras_we;
   logic [PW-1:0]   ras_waddr;
   logic            fire;
   logic            empty;

   assign empty     = (count_q == '0);
   assign ras_empty = empty;
   assign pc_valid  = (state_q == RUN);
   assign fire      = pc_valid && if_ready && !stall;
   assign Iaddress  = pc_q;
   assign misaligned_fault = fault_q;
   assign fault_addr       = fault_addr_q;

   // Next-state, next-PC and RAS update selection
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      fault_d      = fault_q;
      fault_addr_d = fault_addr_q;
      top_d        = top_q;
      count_d      = count_q;
      ras_we       = 1'b0;
      ras_waddr    = top_q;

      unique case (state_q)
         BOOT: state_d = RUN;
         RUN: begin
            if (trap_en) begin
               count_d = '0;
               if (trap_vector[1:0] != 2'b00) begin
                  state_d      = HALT;
                  fault_d      = 1'b1;
                  fault_addr_d = trap_vector;
               end else begin
                  pc_d = trap_vector;
               end
            end else if (redirect_en) begin
               if (redirect_target[1:0] != 2'b00) begin
                  state_d      = HALT;
                  fault_d      = 1'b1;
                  fault_addr_d = redirect_target;
               end else begin
                  pc_d = redirect_target;
               end
            end else if (fire) begin
               pc_d = pc_q + XLEN'(4);
               if (ras_push && ras_pop && !empty) begin
                  // Return predicted from the old top, then the call replaces it.
                  pc_d   = ras_q[top_q];
                  ras_we = 1'b1;
               end else if (ras_pop && !ras_push) begin
                  if (!empty) begin
                     pc_d    = ras_q[top_q];
                     top_d   = top_q - PW'(1);
                     count_d = count_q - CW'(1);
                  end
               end else if (ras_push) begin
                  // Push onto an empty stack when paired with a pop behaves as a plain push.
                  top_d     = top_q + PW'(1);
                  ras_we    = 1'b1;
                  ras_waddr = top_q + PW'(1);
                  if (count_q != CW'(RAS_DEPTH)) begin
                     count_d = count_q + CW'(1);
                  end
               end
            end
         end
         HALT: begin
            if (trap_en) begin
               count_d = '0;
               if (trap_vector[1:0] != 2'b00) begin
                  fault_addr_d = trap_vector;
               end else begin
                  pc_d    = trap_vector;
                  fault_d = 1'b0;
                  state_d = RUN;
               end
            end
         end
         default: state_d = BOOT;
      endcase
   end

   // Control and PC registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state_q      <= BOOT;
         pc_q         <= XLEN'(RESET_VECTOR);
         fault_q      <= 1'b0;
         fault_addr_q <= '0;
         top_q        <= '0;
         count_q      <= '0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         fault_q      <= fault_d;
         fault_addr_q <= fault_addr_d;
         top_q        <= top_d;
         count_q      <= count_d;
      end
   end

   // Return-address storage; contents are qualified by count, so no reset
   always_ff @(posedge clk) begin
      if (n_reset && ras_we) begin
         ras_q[ras_waddr] <= ras_push_addr;
      end
   end

endmodule

// File: tb/tb_pc_unit.sv
// Directed self-checking bench for pc_unit (RESET_VECTOR=0x100, RAS_DEPTH=4).
module tb_pc_unit;

   logic        clk = 1'b0;
   logic        n_reset;
   logic        if_ready, stall, trap_en, redirect_en, ras_push, ras_pop;
   logic [31:0] trap_vector, redirect_target, ras_push_addr;
   logic [31:0] Iaddress, fault_addr;
   logic        pc_valid, misaligned_fault, ras_empty;

   int unsigned total = 0;
   int unsigned bad   = 0;

   pc_unit #(
      .XLEN(32),
      .RESET_VECTOR(32'h100),
      .RAS_DEPTH(4)
   ) dut (
      .clk(clk),
      .n_reset(n_reset),
      .if_ready(if_ready),
      .stall(stall),
      .trap_en(trap_en),
      .trap_vector(trap_vector),
      .redirect_en(redirect_en),
      .redirect_target(redirect_target),
      .ras_push(ras_push),
      .ras_push_addr(ras_push_addr),
      .ras_pop(ras_pop),
      .Iaddress(Iaddress),
      .pc_valid(pc_valid),
      .misaligned_fault(misaligned_fault),
      .fault_addr(fault_addr),
      .ras_empty(ras_empty)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      n_reset = 1'b0; if_ready = 1'b1; stall = 1'b0;
      trap_en = 1'b0; trap_vector = '0; redirect_en = 1'b0; redirect_target = '0;
      ras_push = 1'b0; ras_push_addr = '0; ras_pop = 1'b0;
      tick(); tick();
      check("rst_pc", Iaddress, 32'h100);
      check("rst_valid", {31'b0, pc_valid}, 32'd0);
      check("rst_fault", {31'b0, misaligned_fault}, 32'd0);
      check("rst_faddr", fault_addr, 32'h0);
      check("rst_empty", {31'b0, ras_empty}, 32'd1);

      // Boot and sequential fetch
      n_reset = 1'b1;
      tick();
      check("boot_pc", Iaddress, 32'h100);
      check("boot_valid", {31'b0, pc_valid}, 32'd1);
      tick(); check("seq1", Iaddress, 32'h104);
      tick(); check("seq2", Iaddress, 32'h108);

      // Handshake hold and stalled redirect
      redirect_en = 1'b1; redirect_target = 32'h200;
      tick(); check("redir200", Iaddress, 32'h200);
      redirect_en = 1'b0; if_ready = 1'b0;
      tick(); check("hold1", Iaddress, 32'h200);
      tick(); check("hold2", Iaddress, 32'h200);
      tick(); check("hold3", Iaddress, 32'h200);
      if_ready = 1'b1; stall = 1'b1; redirect_en = 1'b1; redirect_target = 32'h400;
      tick(); check("stall_redir", Iaddress, 32'h400);
      redirect_en = 1'b0;
      tick(); check("stall_hold", Iaddress, 32'h400);
      stall = 1'b0;

      // Trap beats redirect and clears the RAS
      ras_push = 1'b1; ras_push_addr = 32'h999C;
      tick(); check("push_pc", Iaddress, 32'h404);
      check("push_nonempty", {31'b0, ras_empty}, 32'd0);
      ras_push = 1'b0;
      trap_en = 1'b1; trap_vector = 32'h80; redirect_en = 1'b1; redirect_target = 32'h300;
      tick(); check("prio_pc", Iaddress, 32'h80);
      check("prio_empty", {31'b0, ras_empty}, 32'd1);
      trap_en = 1'b0; redirect_en = 1'b0;

      // Fill past depth, then drain
      ras_push = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         ras_push_addr = 32'(i * 16);
         tick();
      end
      ras_push = 1'b0;
      check("fill_pc", Iaddress, 32'h94);
      check("fill_nonempty", {31'b0, ras_empty}, 32'd0);
      ras_pop = 1'b1;
      tick(); check("pop1", Iaddress, 32'h50);
      tick(); check("pop2", Iaddress, 32'h40);
      tick(); check("pop3", Iaddress, 32'h30);
      tick(); check("pop4", Iaddress, 32'h20);
      check("pop4_empty", {31'b0, ras_empty}, 32'd1);
      tick(); check("pop5_seq", Iaddress, 32'h24);
      ras_pop = 1'b0;

      // Simultaneous push and pop
      ras_push = 1'b1; ras_push_addr = 32'h50;
      tick(); check("pre_pushpop", Iaddress, 32'h28);
      ras_push_addr = 32'h60; ras_pop = 1'b1;
      tick(); check("pushpop_pc", Iaddress, 32'h50);
      check("pushpop_cnt", {31'b0, ras_empty}, 32'd0);
      ras_push = 1'b0;
      tick(); check("pop_new_top", Iaddress, 32'h60);
      check("pop_new_empty", {31'b0, ras_empty}, 32'd1);
      ras_pop = 1'b0;

      // Misaligned redirect, HALT, trap recovery
      redirect_en = 1'b1; redirect_target = 32'h1002;
      tick();
      check("mis_fault", {31'b0, misaligned_fault}, 32'd1);
      check("mis_faddr", fault_addr, 32'h1002);
      check("mis_valid", {31'b0, pc_valid}, 32'd0);
      check("mis_pc", Iaddress, 32'h60);
      redirect_target = 32'h2000;
      tick();
      check("halt_ign_pc", Iaddress, 32'h60);
      check("halt_ign_valid", {31'b0, pc_valid}, 32'd0);
      redirect_en = 1'b0; trap_en = 1'b1; trap_vector = 32'h80;
      tick();
      check("rec_pc", Iaddress, 32'h80);
      check("rec_valid", {31'b0, pc_valid}, 32'd1);
      check("rec_fault", {31'b0, misaligned_fault}, 32'd0);
      trap_en = 1'b0;

      // Wrap at top of address space
      redirect_en = 1'b1; redirect_target = 32'hFFFF_FFFC;
      tick(); check("wrap_pre", Iaddress, 32'hFFFF_FFFC);
      redirect_en = 1'b0;
      tick(); check("wrap", Iaddress, 32'h0);
      ras_push = 1'b1; ras_push_addr = 32'h44;
      tick(); check("wrap_next", Iaddress, 32'h4);
      ras_push = 1'b0;

      // Reset while halted
      redirect_en = 1'b1; redirect_target = 32'h3;
      tick(); check("halt2_fault", {31'b0, misaligned_fault}, 32'd1);
      redirect_en = 1'b0; n_reset = 1'b0;
      tick();
      check("rst2_pc", Iaddress, 32'h100);
      check("rst2_valid", {31'b0, pc_valid}, 32'd0);
      check("rst2_fault", {31'b0, misaligned_fault}, 32'd0);
      check("rst2_faddr", fault_addr, 32'h0);
      check("rst2_empty", {31'b0, ras_empty}, 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
